// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
//
// Parametrised general-purpose register file with a per-register busy
// scoreboard for outstanding loads. Register 0 reads as zero and is never
// busy. Two write ports: execute writeback (wb) and load return (ld). When
// both write the same register in one cycle, wb data wins. The ld busy clear
// still applies in that cycle.
//
// Optional feature: define REG_FILE_BYPASS_EN to forward same-cycle writes
// and load-return busy clears to the read ports. Without it, reads see
// registered state only.
//
// Parameters:
//   DATA_WIDTH  register width in bits
//   REG_COUNT   number of registers (power of two, >= 2)
//   READ_PORTS  number of independent combinational read ports (>= 1)
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   wb_en_i/wb_addr_i/wb_data_i execute writeback port
//   ld_en_i/ld_addr_i/ld_data_i load-return port (also clears busy)
//   rsv_en_i/rsv_addr_i         reserve request (sets busy)
//   rd_addr_i                   packed read addresses, port k at [k*AW +: AW]
//   rd_data_o                   packed read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   rd_busy_o                   busy flag of each addressed register
//   busy_any_o                  OR of the registered busy vector
// -----------------------------------------------------------------------------
module reg_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    parameter int READ_PORTS = 2,
    localparam int AW        = $clog2(REG_COUNT)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wb_en_i,
    input  logic [AW-1:0]                    wb_addr_i,
    input  logic [DATA_WIDTH-1:0]            wb_data_i,
    input  logic                             ld_en_i,
    input  logic [AW-1:0]                    ld_addr_i,
    input  logic [DATA_WIDTH-1:0]            ld_data_i,
    input  logic                             rsv_en_i,
    input  logic [AW-1:0]                    rsv_addr_i,
    input  logic [READ_PORTS*AW-1:0]         rd_addr_i,
    output logic [READ_PORTS*DATA_WIDTH-1:0] rd_data_o,
    output logic [READ_PORTS-1:0]            rd_busy_o,
    output logic                             busy_any_o
);

    // Registers 1..REG_COUNT-1 only; register 0 has no storage.
    logic [DATA_WIDTH-1:0] regs [1:REG_COUNT-1];
    logic [REG_COUNT-1:0]  busy;
    logic [REG_COUNT-1:0]  busy_next;

    // Reserve is applied after the clear so that it wins on a collision.
    // Bit 0 stays 0, which also drops reserves of register 0.
    always_comb begin
        busy_next = '0;
        for (int r = 1; r < REG_COUNT; r++) begin
            busy_next[r] = (rsv_en_i && (rsv_addr_i == AW'(r))) ||
                           (busy[r] && !(ld_en_i && (ld_addr_i == AW'(r))));
        end
    end

    // Loop starts at 1, so writes to register 0 are dropped on both ports.
    // The wb branch is tested first, so wb data beats ld data on a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 1; r < REG_COUNT; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            for (int r = 1; r < REG_COUNT; r++) begin
                if (wb_en_i && (wb_addr_i == AW'(r))) begin
                    regs[r] <= wb_data_i;
                end else if (ld_en_i && (ld_addr_i == AW'(r))) begin
                    regs[r] <= ld_data_i;
                end
            end
            busy <= busy_next;
        end
    end

    // Combinational read ports. Address 0 matches no stored register and
    // falls through to the zero defaults.
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            for (int r = 1; r < REG_COUNT; r++) begin
                if (rd_addr_i[p*AW +: AW] == AW'(r)) begin
                    rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = regs[r];
                    rd_busy_o[p]                          = busy[r];
                end
            end
`ifdef REG_FILE_BYPASS_EN
            if (rd_addr_i[p*AW +: AW] != '0) begin
                // ld forwarding first, so a matching wb overrides it below.
                if (ld_en_i && (ld_addr_i == rd_addr_i[p*AW +: AW])) begin
                    rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = ld_data_i;
                    // A same-cycle reserve keeps the register busy, so the
                    // clear is only forwarded when no reserve hits.
                    if (!(rsv_en_i && (rsv_addr_i == rd_addr_i[p*AW +: AW]))) begin
                        rd_busy_o[p] = 1'b0;
                    end
                end
                if (wb_en_i && (wb_addr_i == rd_addr_i[p*AW +: AW])) begin
                    rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = wb_data_i;
                end
            end
`endif
        end
    end

    // Registered busy only; never forwarded.
    assign busy_any_o = |busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_sb
//
// Self-checking bench for reg_file_sb. Instance "a" uses default parameters
// (32x32, 2 read ports) and is checked against a behavioural model. Instance
// "b" uses DATA_WIDTH=64, REG_COUNT=16, READ_PORTS=3 for the parameter sweep.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_reg_file_sb;

    localparam int DW  = 32;
    localparam int RC  = 32;
    localparam int RP  = 2;
    localparam int AW  = 5;
    localparam int BDW = 64;
    localparam int BRC = 16;
    localparam int BRP = 3;
    localparam int BAW = 4;

    logic clk;
    logic rst_n;

    // instance a
    logic              wb_en, ld_en, rsv_en;
    logic [AW-1:0]     wb_addr, ld_addr, rsv_addr;
    logic [DW-1:0]     wb_data, ld_data;
    logic [RP*AW-1:0]  rd_addr;
    logic [RP*DW-1:0]  rd_data;
    logic [RP-1:0]     rd_busy;
    logic              busy_any;

    // instance b
    logic              b_wb_en, b_ld_en, b_rsv_en;
    logic [BAW-1:0]    b_wb_addr, b_ld_addr, b_rsv_addr;
    logic [BDW-1:0]    b_wb_data, b_ld_data;
    logic [BRP*BAW-1:0] b_rd_addr;
    logic [BRP*BDW-1:0] b_rd_data;
    logic [BRP-1:0]    b_rd_busy;
    logic              b_busy_any;

    int vectors;
    int miscompares;

    // behavioural model of instance a
    logic [DW-1:0] mregs [RC];
    logic [RC-1:0] mbusy;

    reg_file_sb dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_en_i    (wb_en),
        .wb_addr_i  (wb_addr),
        .wb_data_i  (wb_data),
        .ld_en_i    (ld_en),
        .ld_addr_i  (ld_addr),
        .ld_data_i  (ld_data),
        .rsv_en_i   (rsv_en),
        .rsv_addr_i (rsv_addr),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .rd_busy_o  (rd_busy),
        .busy_any_o (busy_any)
    );

    reg_file_sb #(
        .DATA_WIDTH (BDW),
        .REG_COUNT  (BRC),
        .READ_PORTS (BRP)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_en_i    (b_wb_en),
        .wb_addr_i  (b_wb_addr),
        .wb_data_i  (b_wb_data),
        .ld_en_i    (b_ld_en),
        .ld_addr_i  (b_ld_addr),
        .ld_data_i  (b_ld_data),
        .rsv_en_i   (b_rsv_en),
        .rsv_addr_i (b_rsv_addr),
        .rd_addr_i  (b_rd_addr),
        .rd_data_o  (b_rd_data),
        .rd_busy_o  (b_rd_busy),
        .busy_any_o (b_busy_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected read value for the current registered model plus current inputs.
    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        if (a == 0) return '0;
        d = mregs[a];
`ifdef REG_FILE_BYPASS_EN
        if (wb_en && wb_addr == a) d = wb_data;
        else if (ld_en && ld_addr == a) d = ld_data;
`endif
        return d;
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        logic b;
        if (a == 0) return 1'b0;
        b = mbusy[a];
`ifdef REG_FILE_BYPASS_EN
        if (ld_en && ld_addr == a && !(rsv_en && rsv_addr == a)) b = 1'b0;
`endif
        return b;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < RC; i++) mregs[i] = '0;
        mbusy = '0;
    endtask

    // Apply the clock edge to the model: ld stored, then wb overwrites it;
    // clear busy on ld, then reserve sets it (reserve wins).
    task automatic model_update();
        if (ld_en && ld_addr != 0) mregs[ld_addr] = ld_data;
        if (wb_en && wb_addr != 0) mregs[wb_addr] = wb_data;
        if (ld_en) mbusy[ld_addr] = 1'b0;
        if (rsv_en && rsv_addr != 0) mbusy[rsv_addr] = 1'b1;
        mbusy[0] = 1'b0;
    endtask

    task automatic drive_check();
        @(negedge clk);
        for (int p = 0; p < RP; p++) begin
            chk($sformatf("rd_data%0d@%0d", p, rd_addr[p*AW +: AW]),
                64'(rd_data[p*DW +: DW]), 64'(exp_rd(rd_addr[p*AW +: AW])));
            chk($sformatf("rd_busy%0d@%0d", p, rd_addr[p*AW +: AW]),
                64'(rd_busy[p]), 64'(exp_busy(rd_addr[p*AW +: AW])));
        end
        chk("busy_any", 64'(busy_any), 64'(|mbusy));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        wb_en = 0; ld_en = 0; rsv_en = 0;
        wb_addr = 0; ld_addr = 0; rsv_addr = 0;
        wb_data = 0; ld_data = 0;
    endtask

    task automatic rd2(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    initial begin
        logic [BDW-1:0] bexp;
        vectors = 0;
        miscompares = 0;
        model_clear();

        b_wb_en = 0; b_ld_en = 0; b_rsv_en = 0;
        b_wb_addr = 0; b_ld_addr = 0; b_rsv_addr = 0;
        b_wb_data = 0; b_ld_data = 0; b_rd_addr = 0;

        // Reset with writes and reserves active
        rst_n = 0;
        wb_en = 1; wb_addr = 5'd4; wb_data = 32'hCAFE_F00D;
        ld_en = 1; ld_addr = 5'd6; ld_data = 32'h1234_5678;
        rsv_en = 1; rsv_addr = 5'd2;
        rd2(5'd4, 5'd2);
        @(posedge clk); @(posedge clk); #1;
        idle();
        rst_n = 1;
        drive_check();
        chk("reset_rd0", 64'(rd_data[0 +: DW]), 64'h0);
        chk("reset_rd1", 64'(rd_data[DW +: DW]), 64'h0);
        chk("reset_busy", 64'(rd_busy), 64'h0);
        chk("reset_busy_any", 64'(busy_any), 64'h0);
        tick();
        rd2(5'd6, 5'd31);
        drive_check();
        tick();

        // x0 write dropped
        wb_en = 1; wb_addr = 0; wb_data = 32'hDEAD_BEEF;
        rd2(0, 0);
        drive_check();
        tick();
        idle();
        drive_check();
        chk("x0_rd0", 64'(rd_data[0 +: DW]), 64'h0);
        chk("x0_rd1", 64'(rd_data[DW +: DW]), 64'h0);
        chk("x0_busy", 64'(rd_busy), 64'h0);
        tick();

        // Write conflict: wb beats ld
        wb_en = 1; wb_addr = 5'd5; wb_data = 32'h11;
        ld_en = 1; ld_addr = 5'd5; ld_data = 32'h22;
        rd2(5'd1, 5'd2);
        drive_check();
        tick();
        idle();
        rd2(5'd5, 5'd5);
        drive_check();
        chk("conflict_rd5", 64'(rd_data[0 +: DW]), 64'h11);
        tick();
        ld_en = 1; ld_addr = 5'd6; ld_data = 32'h33;
        wb_en = 1; wb_addr = 5'd7; wb_data = 32'h44;
        drive_check();
        tick();
        idle();
        rd2(5'd6, 5'd7);
        drive_check();
        chk("ld_rd6", 64'(rd_data[0 +: DW]), 64'h33);
        chk("wb_rd7", 64'(rd_data[DW +: DW]), 64'h44);
        tick();

        // Scoreboard
        rsv_en = 1; rsv_addr = 5'd9;
        rd2(5'd9, 5'd9);
        drive_check();
        tick();
        idle();
        drive_check();
        chk("rsv_busy9", 64'(rd_busy[0]), 64'h1);
        chk("rsv_busy_any", 64'(busy_any), 64'h1);
        tick();
        ld_en = 1; ld_addr = 5'd9; ld_data = 32'h55;
        rsv_en = 1; rsv_addr = 5'd9;
        drive_check();
        chk("rsv_ld_same_busy", 64'(rd_busy[0]), 64'h1);
        tick();
        idle();
        drive_check();
        chk("rsv_beats_clear", 64'(rd_busy[0]), 64'h1);
        tick();
        ld_en = 1; ld_addr = 5'd9; ld_data = 32'h55;
        drive_check();
        tick();
        idle();
        drive_check();
        chk("clr_busy9", 64'(rd_busy[0]), 64'h0);
        chk("clr_data9", 64'(rd_data[0 +: DW]), 64'h55);
        chk("clr_busy_any", 64'(busy_any), 64'h0);
        tick();

        // Bypass / no-bypass visibility
        wb_en = 1; wb_addr = 5'd3; wb_data = 32'hA5A5_A5A5;
        rd2(5'd3, 5'd0);
        drive_check();
`ifdef REG_FILE_BYPASS_EN
        chk("bypass_same", 64'(rd_data[0 +: DW]), 64'hA5A5_A5A5);
`else
        chk("nobypass_old", 64'(rd_data[0 +: DW]), 64'h0);
`endif
        tick();
        idle();
        drive_check();
        chk("bypass_next", 64'(rd_data[0 +: DW]), 64'hA5A5_A5A5);
        tick();

        // Randomised traffic with collisions encouraged
        for (int n = 0; n < 300; n++) begin
            wb_en  = 1'($urandom_range(0, 1));
            ld_en  = 1'($urandom_range(0, 1));
            rsv_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                wb_addr  = 5'($urandom_range(0, 7));
                ld_addr  = 5'($urandom_range(0, 7));
                rsv_addr = 5'($urandom_range(0, 7));
                rd2(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            end else begin
                wb_addr  = 5'($urandom_range(0, 31));
                ld_addr  = 5'($urandom_range(0, 31));
                rsv_addr = 5'($urandom_range(0, 31));
                rd2(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            end
            wb_data = $urandom;
            ld_data = $urandom;
            drive_check();
            tick();
        end
        idle();

        // Parameter sweep on instance b
        for (int r = 1; r < BRC; r++) begin
            b_wb_en = 1; b_wb_addr = 4'(r);
            b_wb_data = {32'hC0DE_0000 + 32'(r), ~(32'(r) * 32'h0101_0101)};
            tick();
        end
        b_wb_en = 0; b_wb_addr = 0; b_wb_data = 0;
        for (int r = 0; r < BRC; r++) begin
            b_rd_addr = {4'(r), 4'(r), 4'(r)};
            bexp = (r == 0) ? 64'h0 : {32'hC0DE_0000 + 32'(r), ~(32'(r) * 32'h0101_0101)};
            @(negedge clk);
            for (int p = 0; p < BRP; p++) begin
                chk($sformatf("sweep_p%0d_r%0d", p, r), b_rd_data[p*BDW +: BDW], bexp);
            end
            chk($sformatf("sweep_busy_r%0d", r), 64'(b_rd_busy), 64'h0);
            tick();
        end
        chk("sweep_busy_any", 64'(b_busy_any), 64'h0);

        // Asynchronous reset mid-operation
        wb_en = 1; wb_addr = 5'd12; wb_data = 32'h0BAD_0BAD;
        rsv_en = 1; rsv_addr = 5'd12;
        tick();
        idle();
        rd2(5'd12, 5'd9);
        b_rd_addr = {4'd15, 4'd7, 4'd1};
        drive_check();
        chk("pre_async_rd12", 64'(rd_data[0 +: DW]), 64'h0BAD_0BAD);
        #2;
        rst_n = 0;
        #1;
        chk("async_rd12", 64'(rd_data[0 +: DW]), 64'h0);
        chk("async_rd9", 64'(rd_data[DW +: DW]), 64'h0);
        chk("async_busy_any", 64'(busy_any), 64'h0);
        chk("async_b_rd", 64'(|b_rd_data), 64'h0);
        model_clear();
        wb_en = 1; wb_addr = 5'd8; wb_data = 32'hFFFF;
        rsv_en = 1; rsv_addr = 5'd8;
        @(posedge clk); #1;
        idle();
        rst_n = 1;
        rd2(5'd8, 5'd12);
        drive_check();
        chk("reset_drop_rd8", 64'(rd_data[0 +: DW]), 64'h0);
        chk("reset_drop_busy8", 64'(rd_busy[0]), 64'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
